// File: rtl/denklem_seq_if.sv
// Handshake and data bundle for the denklem_seq polynomial evaluator.
// The master drives start/x/coef; the slave returns busy/done/y/ovf.
interface denklem_seq_if #(
    parameter int X_W = 3,
    parameter int C_W = 4,
    parameter int DEG = 2,
    parameter int Y_W = 8
);
    logic                   start;
    logic [X_W-1:0]         x;
    logic [(DEG+1)*C_W-1:0] coef;
    logic                   busy;
    logic                   done;
    logic [Y_W-1:0]         y;
    logic                   ovf;

    modport master (
        output start, x, coef,
        input  busy, done, y, ovf
    );

    modport slave (
        input  start, x, coef,
        output busy, done, y, ovf
    );
endinterface

// File: rtl/denklem_seq.sv
// Sequential Horner polynomial evaluator, one multiply-accumulate per clock.
// Optional macro DENKLEM_SAT_EN saturates y once any Horner step overflows.
module denklem_seq #(
    parameter int X_W = 3,
    parameter int C_W = 4,
    parameter int DEG = 2,
    parameter int Y_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    denklem_seq_if.slave bus
);
    localparam int W  = Y_W + X_W + 1;
    localparam int IW = $clog2(DEG + 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(DEG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state;
    logic [Y_W-1:0]         acc;
    logic [X_W-1:0]         x_q;
    logic [(DEG+1)*C_W-1:0] coef_q;
    logic [IW-1:0]          idx;
    logic                   ovf_int;
    logic                   busy_q;
    logic                   done_q;
    logic [Y_W-1:0]         y_q;
    logic                   ovf_q;

    logic [C_W-1:0]         c_sel;
    logic [W-1:0]           mac;
    logic                   ovf_nxt;
    logic [Y_W-1:0]         y_nxt;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.ovf  = ovf_q;

    // mac is wide enough that acc*x + c never truncates
    always_comb begin
        c_sel   = coef_q[idx*C_W +: C_W];
        mac     = W'(acc) * W'(x_q) + W'(c_sel);
        ovf_nxt = ovf_int | (|mac[W-1:Y_W]);
`ifdef DENKLEM_SAT_EN
        y_nxt   = ovf_nxt ? '1 : mac[Y_W-1:0];
`else
        y_nxt   = mac[Y_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            x_q     <= '0;
            coef_q  <= '0;
            idx     <= '0;
            ovf_int <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q     <= bus.x;
                        coef_q  <= bus.coef;
                        acc     <= Y_W'(bus.coef[DEG*C_W +: C_W]);
                        idx     <= IDX_TOP;
                        ovf_int <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc     <= mac[Y_W-1:0];
                    ovf_int <= ovf_nxt;
                    if (idx == '0) begin
                        y_q    <= y_nxt;
                        ovf_q  <= ovf_nxt;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_denklem_seq.sv
// Self-checking bench for denklem_seq: default (DEG=2) and DEG=3 instances,
// compared against a direct power-sum model of the polynomial.
module tb_denklem_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    denklem_seq_if #(.X_W(3), .C_W(4), .DEG(2), .Y_W(8)) b1 ();
    denklem_seq #(.X_W(3), .C_W(4), .DEG(2), .Y_W(8)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    denklem_seq_if #(.X_W(3), .C_W(4), .DEG(3), .Y_W(12)) b3 ();
    denklem_seq #(.X_W(3), .C_W(4), .DEG(3), .Y_W(12)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    // Exact sum of c[i]*x^i; overflow iff the exact value exceeds the range
    function automatic void model(
        input  int     deg,
        input  int     cw,
        input  int     yw,
        input  longint xv,
        input  longint cf,
        output longint ye,
        output bit     oe
    );
        longint exact;
        longint p;
        longint mx;
        exact = 0;
        p = 1;
        for (int i = 0; i <= deg; i++) begin
            exact += ((cf >> (i * cw)) & ((64'sd1 << cw) - 1)) * p;
            p *= xv;
        end
        mx = (64'sd1 << yw) - 1;
        oe = exact > mx;
`ifdef DENKLEM_SAT_EN
        ye = oe ? mx : exact;
`else
        ye = exact & mx;
`endif
    endfunction

    task automatic run1(input logic [2:0] xv, input logic [11:0] cf,
                        input string name);
        longint ye;
        bit     oe;
        int     n;
        model(2, 4, 8, longint'(xv), longint'(cf), ye, oe);
        @(negedge clk);
        b1.start = 1'b1;
        b1.x     = xv;
        b1.coef  = cf;
        @(negedge clk);
        b1.start = 1'b0;
        b1.x     = 3'($urandom);
        b1.coef  = 12'($urandom);
        n = 1;
        while (!b1.done && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL %s latency: got %0d want 3", name, n);
        end
        checks++;
        if (b1.y !== 8'(ye)) begin
            failures++;
            $display("FAIL %s y: got %0d want %0d", name, b1.y, ye);
        end
        checks++;
        if (b1.ovf !== oe) begin
            failures++;
            $display("FAIL %s ovf: got %0b want %0b", name, b1.ovf, oe);
        end
        checks++;
        if (b1.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy at done: got %0b want 1", name, b1.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b1.start = ~b1.start;
            b1.x     = 3'($urandom);
            b1.coef  = 12'($urandom);
            checks++;
            if ({b1.busy, b1.done, b1.ovf, b1.y} !== 11'd0) begin
                failures++;
                $display("FAIL reset: busy=%0b done=%0b ovf=%0b y=%0d want 0",
                         b1.busy, b1.done, b1.ovf, b1.y);
            end
        end
        @(negedge clk);
        b1.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run1(3'd7, {4'd1, 4'd2, 4'd3}, "basic_x7");
        run1(3'd0, {4'd1, 4'd2, 4'd3}, "basic_x0");
        for (int xv = 7; xv >= 0; xv--)
            run1(3'(xv), {4'd1, 4'd2, 4'd3}, "sweep");
    endtask

    task automatic test_overflow();
        run1(3'd7, 12'hFFF, "overflow");
`ifdef DENKLEM_SAT_EN
        checks++;
        if (b1.y !== 8'd255) begin
            failures++;
            $display("FAIL overflow_const: got %0d want 255", b1.y);
        end
`else
        checks++;
        if (b1.y !== 8'd87) begin
            failures++;
            $display("FAIL overflow_const: got %0d want 87", b1.y);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run1(3'($urandom), 12'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        longint ye;
        bit     oe;
        int     ndone;
        int     last;
        model(2, 4, 8, 64'd3, 64'h5A7, ye, oe);
        ndone = 0;
        last = -1;
        @(negedge clk);
        b1.start = 1'b1;
        b1.x     = 3'd3;
        b1.coef  = 12'h5A7;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 16) b1.start = 1'b0;
            if (b1.done) begin
                ndone++;
                checks++;
                if (n != 3 + 4 * (ndone - 1)) begin
                    failures++;
                    $display("FAIL b2b spacing: done at %0d prev %0d", n, last);
                end
                checks++;
                if (b1.y !== 8'(ye) || b1.ovf !== oe) begin
                    failures++;
                    $display("FAIL b2b result: got %0d/%0b want %0d/%0b",
                             b1.y, b1.ovf, ye, oe);
                end
                last = n;
            end
        end
        checks++;
        if (ndone != 4) begin
            failures++;
            $display("FAIL b2b count: got %0d want 4", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        run1(3'd5, {4'd3, 4'd1, 4'd4}, "pre_abort");
        @(negedge clk);
        b1.start = 1'b1;
        b1.x     = 3'd6;
        b1.coef  = 12'h9C2;
        @(negedge clk);
        b1.start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b1.busy, b1.done, b1.ovf, b1.y} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset: busy=%0b done=%0b ovf=%0b y=%0d want 0",
                     b1.busy, b1.done, b1.ovf, b1.y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b1.done || b1.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset no_done: got %0d active cycles want 0", seen);
        end
        run1(3'd4, {4'd2, 4'd7, 4'd1}, "post_abort");
    endtask

    task automatic test_deg3();
        longint ye;
        bit     oe;
        int     n;
        model(3, 4, 12, 64'd5, 64'h1001, ye, oe);
        @(negedge clk);
        b3.start = 1'b1;
        b3.x     = 3'd5;
        b3.coef  = {4'd1, 4'd0, 4'd0, 4'd1};
        @(negedge clk);
        b3.start = 1'b0;
        b3.x     = 3'd2;
        n = 1;
        while (!b3.done && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL deg3 latency: got %0d want 4", n);
        end
        checks++;
        if (b3.y !== 12'(ye) || b3.y !== 12'd126) begin
            failures++;
            $display("FAIL deg3 y: got %0d want %0d", b3.y, ye);
        end
        checks++;
        if (b3.ovf !== oe) begin
            failures++;
            $display("FAIL deg3 ovf: got %0b want %0b", b3.ovf, oe);
        end
    endtask

    initial begin
        b1.start = 1'b0;
        b1.x     = '0;
        b1.coef  = '0;
        b3.start = 1'b0;
        b3.x     = '0;
        b3.coef  = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_deg3();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
